ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer for the single-port data RAM (synchronous write, combinational read). It shares the RAM between port 0 (CPU memory interface) and port 1 (loader/DMA side). Each port uses a req/ack handshake. Contention is resolved round-robin, and an optional lock gives a port exclusive back-to-back access for read-modify-write sequences. The block sits between both requesters and the RAM's `load`/`address`/`in`/`out` pins.

## Interface
- `ADDR_W`, 15: RAM address width.
- `DATA_W`, 16: RAM data width.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `p0_req`, `p1_req`  in  1  access request; held with `we`/`addr`/`wdata`/`lock` stable until `ack`.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  `ADDR_W`  word address.
- `p0_wdata`, `p1_wdata`  in  `DATA_W`  write data.
- `p0_lock`, `p1_lock`  in  1  keep ownership after this access.
- `p0_ack`, `p1_ack`  out  1  one-cycle pulse, access complete.
- `p0_rdata`, `p1_rdata`  out  `DATA_W`  registered read data, valid while `ack` is high; holds otherwise.
- `ram_load`  out  1  to RAM `load`.
- `ram_address`  out  `ADDR_W`  to RAM `address`.
- `ram_in`  out  `DATA_W`  to RAM `in`.
- `ram_out`  in  `DATA_W`  from RAM `out`.

## Operation
- State: `last` (port granted most recently), `owner` ∈ {NONE, P0, P1} (lock holder), registered `pN_ack`, registered `pN_rdata`.
- Eligibility, per cycle: `elig_i = pi_req & ~pi_ack`. A port is never granted in its own ack cycle, so each port issues at most one access every 2 cycles.
- Lock mask: if `owner` = Pk, only port k is eligible. Port k is not eligible during its ack cycle, so that cycle is idle (no grant).
- Grant, combinational:
  - Only one port eligible: grant that port.
  - Both eligible: grant the port ≠ `last`.
  - None eligible: no grant.
- RAM drive:
  - With grant i: `ram_address = pi_addr`, `ram_in = pi_wdata`, `ram_load = pi_we`.
  - With no grant: `ram_load = 0`, `ram_address = 0`, `ram_in = 0`.
- On a clock edge with grant i:
  - `pi_ack <= 1`; other port's ack `<= 0`.
  - If read: `pi_rdata <= ram_out`. If write: `pi_rdata` holds.
  - `last <= i`.
  - `owner <= pi_lock ? Pi : NONE`.
- Lock release: when `owner` = Pk and `pk_req` = 0 in a cycle where `pk_ack` = 0, `owner <= NONE` at that edge. The other port becomes eligible the following cycle.
- No address range checking: the full `ADDR_W` space is passed through.

## Timing
- Reset: all `ack` = 0, all `rdata` = 0, `ram_load` = 0, `ram_address` = 0, `ram_in` = 0, `last` = P1 (port 0 wins the first tie), `owner` = NONE.
- Reset mid-access drops any pending ack. A requester still holding `req` is re-arbitrated from reset state on the first cycle after `reset` falls.
- Latency: request granted in cycle N → `ack` and `rdata` in cycle N+1. The requester may change its request fields from N+2 onward (or drop `req` in N+1).
- Uncontended single port: one access every 2 cycles.
- Two ports contending: alternating grants, one RAM access every cycle.
- Write in cycle N followed by a read of the same address in cycle N+1 (by either port) returns the new data.
- Simultaneous first requests after reset: P0 is granted in cycle N, P1 in cycle N+1.

## Test plan
- Single read: preload `mem[0x0010]` = 0xBEEF; `p0_req` with `we` = 0, `addr` = 0x0010 at cycle 1 → `ram_load` = 0 in cycle 1; `p0_ack` = 1 and `p0_rdata` = 0xBEEF in cycle 2; no grant in cycle 2.
- Tie and alternation: both ports request reads continuously from reset → grants P0, P1, P0, P1 on consecutive cycles; each ack arrives exactly one cycle after its grant.
- Write-then-read: P0 writes 0x1234 to 0x0005 in cycle N; P1 reads 0x0005 in cycle N+1 → `p1_rdata` = 0x1234 in N+2; `p0_rdata` unchanged.
- Lock: P1 performs a locked read of 0x0020, then an unlocked write of 0x0020 = 0x5555, while P0 requests throughout → P0 is not granted until after P1's unlocked write is acked; the cycle between P1's two accesses is idle.
- Lock release by drop: P0 takes the lock and then deasserts `req` → `owner` returns to NONE; P1 is granted on the next cycle.
- Reset mid-operation: assert `reset` in the ack cycle of a P1 read → `p1_ack` = 0 and `p1_rdata` = 0 the next cycle; with both requests still held, P0 is granted first after reset.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - port bundle between both RAM requesters, the arbiter and the RAM pins
interface ram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_lock;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_lock;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    input  ram_out,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output ram_load, ram_address, ram_in
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    output ram_out,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  ram_load, ram_address, ram_in
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-port arbiter for a single-port RAM with per-port lock
module ram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e            owner_q, owner_d;
  logic              last_q, last_d;     // 0 = port 0 granted last, 1 = port 1
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic elig0, elig1;
  logic gnt0, gnt1;

  // A port is never eligible in its own ack cycle; a lock holder masks the other port.
  always_comb begin
    elig0 = bus.p0_req & ~ack0_q & (owner_q != OWN_P1) & ~reset;
    elig1 = bus.p1_req & ~ack1_q & (owner_q != OWN_P0) & ~reset;
    gnt0  = elig0 & (~elig1 | last_q);
    gnt1  = elig1 & (~elig0 | ~last_q);
  end

  always_comb begin
    bus.ram_load    = 1'b0;
    bus.ram_address = '0;
    bus.ram_in      = '0;
    if (gnt0) begin
      bus.ram_load    = bus.p0_we;
      bus.ram_address = bus.p0_addr;
      bus.ram_in      = bus.p0_wdata;
    end else if (gnt1) begin
      bus.ram_load    = bus.p1_we;
      bus.ram_address = bus.p1_addr;
      bus.ram_in      = bus.p1_wdata;
    end
  end

  always_comb begin
    owner_d  = owner_q;
    last_d   = last_q;
    ack0_d   = gnt0;
    ack1_d   = gnt1;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (gnt0) begin
      last_d  = 1'b0;
      owner_d = bus.p0_lock ? OWN_P0 : OWN_NONE;
      if (!bus.p0_we) rdata0_d = bus.ram_out;
    end else if (gnt1) begin
      last_d  = 1'b1;
      owner_d = bus.p1_lock ? OWN_P1 : OWN_NONE;
      if (!bus.p1_we) rdata1_d = bus.ram_out;
    end else if (owner_q == OWN_P0 && !bus.p0_req && !ack0_q) begin
      owner_d = OWN_NONE;
    end else if (owner_q == OWN_P1 && !bus.p1_req && !ack1_q) begin
      owner_d = OWN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      owner_q  <= owner_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.p0_ack   = ack0_q;
  assign bus.p1_ack   = ack1_q;
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed bench for ram_arbiter with an ack/rdata scoreboard and a RAM model
module tb_ram_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (bus.ram_load === 1'b1) mem[bus.ram_address] = bus.ram_in;
  assign bus.ram_out = mem[bus.ram_address];

  typedef struct {
    int            cyc;
    bit            port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [DW-1:0] r0, r1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_ack(input bit port, input logic [DW-1:0] data);
    exp_t e;
    e.cyc  = cyc + 1;
    e.port = port;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    logic e0, e1;
    logic [DW-1:0] d0, d1;
    e0 = 1'b0; e1 = 1'b0; d0 = '0; d1 = '0;
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].port == 1'b0) begin e0 = 1'b1; d0 = sb[i].data; end
        else begin e1 = 1'b1; d1 = sb[i].data; end
      end
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
    chk("p0_ack", 32'(bus.p0_ack), 32'(e0));
    chk("p1_ack", 32'(bus.p1_ack), 32'(e1));
    if (e0) chk("p0_rdata", 32'(bus.p0_rdata), 32'(d0));
    if (e1) chk("p1_rdata", 32'(bus.p1_rdata), 32'(d1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sb_check();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check_bus(input string tag, input logic load, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    chk({tag, "_load"}, 32'(bus.ram_load), 32'(load));
    chk({tag, "_addr"}, 32'(bus.ram_address), 32'(a));
    chk({tag, "_in"}, 32'(bus.ram_in), 32'(d));
  endtask

  task automatic set_p0(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic lk);
    bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = wd; bus.p0_lock = lk;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic lk);
    bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = wd; bus.p1_lock = lk;
  endtask

  initial begin
    reset = 1'b1;
    set_p0(1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    set_p1(1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    mem[15'h0010] = 16'hBEEF;
    mem[15'h0020] = 16'h7777;
    mem[15'h0030] = 16'hA0A0;
    mem[15'h0031] = 16'hB1B1;
    mem[15'h0040] = 16'h4444;
    r0 = '0; r1 = '0;

    // reset state
    tick(); settle();
    check_bus("rst", 1'b0, 15'h0, 16'h0);
    chk("rst_p0_rdata", 32'(bus.p0_rdata), 32'h0);
    chk("rst_p1_rdata", 32'(bus.p1_rdata), 32'h0);
    tick();

    // single read, idle in its ack cycle, rdata holds afterwards
    reset = 1'b0;
    set_p0(1'b1, 1'b0, 15'h0010, 16'h0, 1'b0);
    settle();
    check_bus("rd_grant", 1'b0, 15'h0010, 16'h0);
    r0 = 16'hBEEF; expect_ack(1'b0, r0);
    tick(); settle();
    check_bus("rd_ackcyc", 1'b0, 15'h0, 16'h0);
    tick(); set_p0(1'b0, 1'b0, 15'h0, 16'h0, 1'b0); settle();
    check_bus("rd_idle", 1'b0, 15'h0, 16'h0);
    tick(); settle();
    chk("rd_hold", 32'(bus.p0_rdata), 32'(r0));

    // tie from reset, then alternation
    tick();
    reset = 1'b1;
    set_p0(1'b1, 1'b0, 15'h0030, 16'h0, 1'b0);
    set_p1(1'b1, 1'b0, 15'h0031, 16'h0, 1'b0);
    settle();
    check_bus("alt_rst", 1'b0, 15'h0, 16'h0);
    tick(); reset = 1'b0; r0 = '0; r1 = '0; settle();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        check_bus("alt_p0", 1'b0, 15'h0030, 16'h0);
        r0 = 16'hA0A0; expect_ack(1'b0, r0);
      end else begin
        check_bus("alt_p1", 1'b0, 15'h0031, 16'h0);
        r1 = 16'hB1B1; expect_ack(1'b1, r1);
      end
      tick();
      if (i == 3) begin
        set_p0(1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
        set_p1(1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
      end
      settle();
    end
    check_bus("alt_end", 1'b0, 15'h0, 16'h0);

    // write then read of the same address by the other port
    tick(); set_p0(1'b1, 1'b1, 15'h0005, 16'h1234, 1'b0); settle();
    check_bus("wr", 1'b1, 15'h0005, 16'h1234);
    expect_ack(1'b0, r0);
    tick();
    set_p0(1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    set_p1(1'b1, 1'b0, 15'h0005, 16'h0, 1'b0);
    settle();
    check_bus("wr_rd", 1'b0, 15'h0005, 16'h0);
    r1 = 16'h1234; expect_ack(1'b1, r1);
    tick(); set_p1(1'b0, 1'b0, 15'h0, 16'h0, 1'b0); settle();
    check_bus("wr_idle", 1'b0, 15'h0, 16'h0);

    // locked read then unlocked write by P1 while P0 waits
    tick(); set_p1(1'b1, 1'b0, 15'h0020, 16'h0, 1'b1); settle();
    check_bus("lk_rd", 1'b0, 15'h0020, 16'h0);
    r1 = 16'h7777; expect_ack(1'b1, r1);
    tick(); set_p0(1'b1, 1'b0, 15'h0040, 16'h0, 1'b0); settle();
    check_bus("lk_idle", 1'b0, 15'h0, 16'h0);
    tick(); set_p1(1'b1, 1'b1, 15'h0020, 16'h5555, 1'b0); settle();
    check_bus("lk_wr", 1'b1, 15'h0020, 16'h5555);
    expect_ack(1'b1, r1);
    tick(); set_p1(1'b0, 1'b0, 15'h0, 16'h0, 1'b0); settle();
    check_bus("lk_p0", 1'b0, 15'h0040, 16'h0);
    r0 = 16'h4444; expect_ack(1'b0, r0);
    tick(); set_p0(1'b0, 1'b0, 15'h0, 16'h0, 1'b0); settle();
    check_bus("lk_end", 1'b0, 15'h0, 16'h0);
    chk("lk_mem", 32'(mem[15'h0020]), 32'h5555);

    // lock taken by P0 and released by dropping req
    tick(); set_p0(1'b1, 1'b0, 15'h0040, 16'h0, 1'b1); settle();
    check_bus("rl_lock", 1'b0, 15'h0040, 16'h0);
    expect_ack(1'b0, r0);
    tick();
    set_p0(1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    set_p1(1'b1, 1'b0, 15'h0031, 16'h0, 1'b0);
    settle();
    check_bus("rl_ackcyc", 1'b0, 15'h0, 16'h0);
    tick(); settle();
    check_bus("rl_release", 1'b0, 15'h0, 16'h0);
    tick(); settle();
    check_bus("rl_p1", 1'b0, 15'h0031, 16'h0);
    r1 = 16'hB1B1; expect_ack(1'b1, r1);
    tick(); set_p1(1'b0, 1'b0, 15'h0, 16'h0, 1'b0); settle();
    check_bus("rl_end", 1'b0, 15'h0, 16'h0);

    // reset during the ack cycle of a P1 read
    tick(); set_p1(1'b1, 1'b0, 15'h0031, 16'h0, 1'b0); settle();
    check_bus("rs_p1", 1'b0, 15'h0031, 16'h0);
    expect_ack(1'b1, r1);
    tick(); reset = 1'b1; set_p0(1'b1, 1'b0, 15'h0030, 16'h0, 1'b0); settle();
    check_bus("rs_in", 1'b0, 15'h0, 16'h0);
    tick(); reset = 1'b0; r0 = '0; r1 = '0; settle();
    chk("rs_p1_rdata", 32'(bus.p1_rdata), 32'h0);
    chk("rs_p0_rdata", 32'(bus.p0_rdata), 32'h0);
    check_bus("rs_p0_first", 1'b0, 15'h0030, 16'h0);
    r0 = 16'hA0A0; expect_ack(1'b0, r0);
    tick(); settle();
    check_bus("rs_p1_next", 1'b0, 15'h0031, 16'h0);
    r1 = 16'hB1B1; expect_ack(1'b1, r1);
    tick();
    set_p0(1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    set_p1(1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    settle();
    check_bus("rs_end", 1'b0, 15'h0, 16'h0);
    tick(); settle();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
